dmem_port_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters:
//     - port 0: pipeline MEM stage
//     - port 1: debug/loader master

---
 rtl/dmem_port_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_port_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Port 1 (debug/loader) may lock the memory for a bounded burst.
module dmem_port_arbiter #(
  parameter int DEPTH    = 32,
  parameter int LOCK_MAX = 8,
  parameter int CW       = 4
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  input  logic        lock1,
  output logic        err,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memRData,
  output logic        stall0
);

  typedef enum logic {NONE, LOCK1} owner_t;

  owner_t        owner, owner_next;
  logic          prio, prio_next;
  logic [CW-1:0] lockcnt, lockcnt_next;
  logic          forced_exit, lock_hold, arb_prio;
  logic          granted, sel_we, in_range;
  logic [31:0]   sel_addr, sel_wdata;

  // Grants are combinational and forced low while reset is held. A forced exit
  // (port 1 has already owned LOCK_MAX cycles) hands this very cycle to port 0.
  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    owner_next   = owner;
    prio_next    = prio;
    lockcnt_next = lockcnt;
    forced_exit  = 1'b0;
    lock_hold    = 1'b0;
    arb_prio     = prio;
    if (resetIn) begin
      forced_exit = (owner == LOCK1) && (lockcnt == CW'(LOCK_MAX)) && req0;
      lock_hold   = (owner == LOCK1) && lock1 && req1 && !forced_exit;
      if (lock_hold) begin
        gnt1       = 1'b1;
        owner_next = LOCK1;
        if (lockcnt != CW'(LOCK_MAX))
          lockcnt_next = lockcnt + CW'(1);
      end else begin
        arb_prio = forced_exit ? 1'b0 : prio;
        if (req0 && req1) begin
          gnt0 = !arb_prio;
          gnt1 = arb_prio;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
        owner_next   = (gnt1 && lock1) ? LOCK1 : NONE;
        lockcnt_next = (gnt1 && lock1) ? CW'(1) : '0;
      end
      if (gnt0)
        prio_next = 1'b1;
      else if (gnt1)
        prio_next = 1'b0;
    end
  end

  always_comb begin
    granted   = gnt0 | gnt1;
    sel_we    = gnt1 ? we1 : we0;
    sel_addr  = gnt1 ? addr1 : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    in_range  = sel_addr < 32'(DEPTH);
    memAddr   = granted ? sel_addr : 32'h0;
    memWData  = granted ? sel_wdata : 32'h0;
    memRead   = granted & ~sel_we & in_range;
    memWrite  = granted & sel_we & in_range;
    stall0    = req0 & ~gnt0;
  end

  // Out-of-range reads still complete, returning zero with a valid strobe.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      owner   <= NONE;
      prio    <= 1'b0;
      lockcnt <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= 32'h0;
      rdata1  <= 32'h0;
      err     <= 1'b0;
    end else begin
      owner   <= owner_next;
      prio    <= prio_next;
      lockcnt <= lockcnt_next;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      err     <= granted & ~in_range;
      if (gnt0 && !we0)
        rdata0 <= in_range ? memRData : 32'h0;
      if (gnt1 && !we1)
        rdata1 <= in_range ? memRData : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small async-read memory model
// attached to the mem* bus.
module tb_dmem_port_arbiter;

  logic        clkIn = 1'b0;
  logic        resetIn;
  logic        req0, we0, req1, we1, lock1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err;
  logic [31:0] rdata0, rdata1;
  logic [31:0] memAddr, memWData, memRData;
  logic        memRead, memWrite, stall0;
  logic [31:0] mem_model [0:31];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clkIn = ~clkIn;

  dmem_port_arbiter #(.DEPTH(32), .LOCK_MAX(8), .CW(4)) dut (
    .clkIn(clkIn), .resetIn(resetIn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .lock1(lock1), .err(err),
    .memAddr(memAddr), .memWData(memWData), .memRead(memRead),
    .memWrite(memWrite), .memRData(memRData), .stall0(stall0)
  );

  // Memory preloads word i with 0x1000_0000+i; read is asynchronous.
  always @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      for (int i = 0; i < 32; i++) mem_model[i] <= 32'h1000_0000 + 32'(i);
    end else if (memWrite) begin
      mem_model[memAddr[4:0]] <= memWData;
    end
  end

  always_comb begin
    memRData = 32'h0;
    if (memAddr < 32'd32) memRData = mem_model[memAddr[4:0]];
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r0, input logic w0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic r1, input logic w1,
                                input logic [31:0] a1, input logic [31:0] d1,
                                input logic l1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    lock1 = l1;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clkIn);
    #1;
  endtask

  initial begin
    logic exp1;
    resetIn = 1'b0;
    apply_stimulus(1, 1, 32'd3, 32'h1, 1, 1, 32'd4, 32'h2, 0);

    $display("[TB] reset");
    @(negedge clkIn);
    check_output("rst_gnt0", gnt0, 0);
    check_output("rst_gnt1", gnt1, 0);
    check_output("rst_memWrite", memWrite, 0);
    check_output("rst_rvalid0", rvalid0, 0);
    check_output("rst_rdata0", rdata0, 0);
    check_output("rst_err", err, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetIn = 1'b1;

    $display("[TB] contention");
    next_cycle();
    apply_stimulus(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 0);
    check_output("rr_c1_gnt0", gnt0, 1);
    check_output("rr_c1_gnt1", gnt1, 0);
    check_output("rr_c1_stall0", stall0, 0);
    next_cycle();
    check_output("rr_c2_gnt1", gnt1, 1);
    check_output("rr_c2_stall0", stall0, 1);
    check_output("rr_c2_memRead", memRead, 1);
    check_output("rr_c2_memAddr", memAddr, 32'd2);
    next_cycle();
    check_output("rr_c3_gnt0", gnt0, 1);
    check_output("rr_c3_rvalid1", rvalid1, 1);
    check_output("rr_c3_rdata1", rdata1, 32'h1000_0002);
    check_output("rr_c3_rvalid0", rvalid0, 0);
    next_cycle();
    check_output("rr_c4_gnt1", gnt1, 1);
    check_output("rr_c4_stall0", stall0, 1);

    $display("[TB] read path");
    next_cycle();
    apply_stimulus(1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    check_output("wr_gnt0", gnt0, 1);
    check_output("wr_memWrite", memWrite, 1);
    check_output("wr_memWData", memWData, 32'hDEAD_BEEF);
    next_cycle();
    apply_stimulus(1, 0, 32'd5, 0, 0, 0, 0, 0, 0);
    check_output("rd_memRead", memRead, 1);
    check_output("rd_rvalid0_after_write", rvalid0, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("rd_rvalid0", rvalid0, 1);
    check_output("rd_rdata0", rdata0, 32'hDEAD_BEEF);
    check_output("idle_memAddr", memAddr, 0);
    next_cycle();
    check_output("rd_rvalid0_drop", rvalid0, 0);
    check_output("rd_rdata0_hold", rdata0, 32'hDEAD_BEEF);

    $display("[TB] cross-port read after write");
    apply_stimulus(1, 1, 32'd6, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 1, 0, 32'd6, 0, 0);
    check_output("raw_gnt1", gnt1, 1);
    next_cycle();
    apply_stimulus(1, 0, 32'd0, 0, 0, 0, 0, 0, 0);
    check_output("raw_rvalid1", rvalid1, 1);
    check_output("raw_rdata1", rdata1, 32'hCAFE_F00D);

    $display("[TB] lock");
    next_cycle();
    apply_stimulus(1, 0, 32'd0, 0, 1, 0, 32'd3, 0, 1);
    for (int i = 0; i < 20; i++) begin
      exp1 = (i % 9) != 8;
      check_output($sformatf("lock_c%0d_gnt1", i), gnt1, exp1);
      check_output($sformatf("lock_c%0d_gnt0", i), gnt0, !exp1);
      next_cycle();
    end

    $display("[TB] async reset mid-lock");
    check_output("mid_gnt1", gnt1, 1);
    check_output("mid_rvalid1", rvalid1, 1);
    #2;
    resetIn = 1'b0;
    #1;
    check_output("arst_gnt1", gnt1, 0);
    check_output("arst_gnt0", gnt0, 0);
    check_output("arst_rvalid1", rvalid1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clkIn);
    resetIn = 1'b1;
    next_cycle();
    apply_stimulus(1, 0, 32'd1, 0, 1, 0, 32'd2, 0, 1);
    check_output("post_rst_gnt0", gnt0, 1);
    check_output("post_rst_gnt1", gnt1, 0);

    $display("[TB] range");
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 1, 0, 32'd40, 0, 0);
    check_output("rng_gnt1", gnt1, 1);
    check_output("rng_memRead", memRead, 0);
    check_output("rng_err_now", err, 0);
    next_cycle();
    apply_stimulus(1, 1, 32'd33, 32'h55, 0, 0, 0, 0, 0);
    check_output("rng_err", err, 1);
    check_output("rng_rvalid1", rvalid1, 1);
    check_output("rng_rdata1", rdata1, 0);
    check_output("rng_wr_memWrite", memWrite, 0);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 1, 0, 32'd31, 0, 0);
    check_output("rng_wr_err", err, 1);
    check_output("edge_memRead", memRead, 1);
    next_cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("edge_err", err, 0);
    check_output("edge_rvalid1", rvalid1, 1);
    check_output("edge_rdata1", rdata1, 32'h1000_001F);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
